// File: rtl/shift_sched.sv
// Address sequencer for the shift partitions: prescaled run/pause/step plus the PR freeze/decouple handshake.
// Optional feature: define SHIFT_SCHED_WRAP_IRQ_EN to add the wrap_irq output.
module shift_sched #(
    parameter int ADDR_W    = 12,
    parameter int PRESCALE  = 2**23,
    parameter int GUARD_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              pause_i,
    input  logic              step_i,
    input  logic              pr_req,
    input  logic              pr_done,
    output logic              shift_en,
    output logic [ADDR_W-1:0] shift_addr,
    output logic              pr_ack,
    output logic [2:0]        state_o
`ifdef SHIFT_SCHED_WRAP_IRQ_EN
    ,
    output logic              wrap_irq
`endif
);

    localparam int PS_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam int GC_W = $clog2(GUARD_CYC + 1);
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);
    localparam logic [GC_W-1:0] GC_MAX = GC_W'(GUARD_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'b000,
        ST_RUN      = 3'b001,
        ST_PAUSE    = 3'b010,
        ST_GUARD    = 3'b011,
        ST_DECOUPLE = 3'b100
    } state_t;

    state_t            state_q, state_d;
    state_t            saved_q, saved_d;
    logic [PS_W-1:0]   ps_q, ps_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [GC_W-1:0]   guard_q, guard_d;
    logic              en_q, en_d;
    logic              ack_q, ack_d;

    always_comb begin
        state_d = state_q;
        saved_d = saved_q;
        ps_d    = ps_q;
        addr_d  = addr_q;
        guard_d = guard_q;
        case (state_q)
            ST_IDLE: begin
                if (pr_req) begin
                    state_d = ST_GUARD;
                    saved_d = ST_IDLE;
                    guard_d = '0;
                end else if (start_i) begin
                    state_d = ST_RUN;
                    ps_d    = '0;
                end
            end
            ST_RUN: begin
                // The prescaler only advances on edges that stay in RUN, so a
                // pause or PR entry freezes it without losing or adding a tick.
                if (pr_req) begin
                    state_d = ST_GUARD;
                    saved_d = ST_RUN;
                    guard_d = '0;
                end else if (pause_i) begin
                    state_d = ST_PAUSE;
                end else if (ps_q == PS_MAX) begin
                    ps_d   = '0;
                    addr_d = addr_q + ADDR_W'(1);
                end else begin
                    ps_d = ps_q + PS_W'(1);
                end
            end
            ST_PAUSE: begin
                if (pr_req) begin
                    state_d = ST_GUARD;
                    saved_d = ST_PAUSE;
                    guard_d = '0;
                end else if (start_i) begin
                    state_d = ST_RUN;
                end else if (step_i) begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            ST_GUARD: begin
                if (!pr_req) begin
                    state_d = saved_q;
                end else if (guard_q == GC_MAX) begin
                    state_d = ST_DECOUPLE;
                end else begin
                    guard_d = guard_q + GC_W'(1);
                end
            end
            ST_DECOUPLE: begin
                if (pr_done) begin
                    state_d = saved_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        en_d  = (state_d == ST_RUN) || (state_d == ST_PAUSE);
        ack_d = (state_d == ST_DECOUPLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            saved_q <= ST_IDLE;
            ps_q    <= '0;
            addr_q  <= '0;
            guard_q <= '0;
            en_q    <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            ps_q    <= ps_d;
            addr_q  <= addr_d;
            guard_q <= guard_d;
            en_q    <= en_d;
            ack_q   <= ack_d;
        end
    end

    assign shift_en   = en_q;
    assign shift_addr = addr_q;
    assign pr_ack     = ack_q;
    assign state_o    = state_q;

`ifdef SHIFT_SCHED_WRAP_IRQ_EN
    logic wrap_irq_q, wrap_irq_d;

    // The address only ever moves by +1, so any change away from all-ones is a wrap.
    always_comb begin
        wrap_irq_d = (addr_q == '1) && (addr_d != addr_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrap_irq_q <= 1'b0;
        end else begin
            wrap_irq_q <= wrap_irq_d;
        end
    end

    assign wrap_irq = wrap_irq_q;
`endif

endmodule

// File: tb/tb_shift_sched.sv
// Scoreboard bench for shift_sched (PRESCALE=4, GUARD_CYC=3, ADDR_W=4).
// Expectations are queued as each cycle of stimulus is applied and compared once the DUT has clocked it.
module tb_shift_sched;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_PAUSE = 3'd2;
    localparam logic [2:0] S_GUARD = 3'd3;
    localparam logic [2:0] S_DEC   = 3'd4;

    localparam logic [4:0] I_NONE  = 5'b00000;
    localparam logic [4:0] I_START = 5'b00001;
    localparam logic [4:0] I_PAUSE = 5'b00010;
    localparam logic [4:0] I_STEP  = 5'b00100;
    localparam logic [4:0] I_REQ   = 5'b01000;
    localparam logic [4:0] I_DONE  = 5'b10000;

    typedef struct {
        string      name;
        logic [3:0] addr;
        logic [2:0] st;
        logic       en;
        logic       ack;
        logic       irq;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_i = 1'b0;
    logic       pause_i = 1'b0;
    logic       step_i = 1'b0;
    logic       pr_req = 1'b0;
    logic       pr_done = 1'b0;
    logic       shift_en;
    logic [3:0] shift_addr;
    logic       pr_ack;
    logic [2:0] state_o;
`ifdef SHIFT_SCHED_WRAP_IRQ_EN
    logic       wrap_irq;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    shift_sched #(
        .ADDR_W   (4),
        .PRESCALE (4),
        .GUARD_CYC(3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start_i),
        .pause_i   (pause_i),
        .step_i    (step_i),
        .pr_req    (pr_req),
        .pr_done   (pr_done),
        .shift_en  (shift_en),
        .shift_addr(shift_addr),
        .pr_ack    (pr_ack),
        .state_o   (state_o)
`ifdef SHIFT_SCHED_WRAP_IRQ_EN
        ,
        .wrap_irq  (wrap_irq)
`endif
    );

    // Drive one cycle of inputs, queue what the DUT must show after the edge, then clock it.
    task automatic apply(input logic [4:0] in, input string nm, input logic [3:0] a,
                         input logic [2:0] s, input logic e, input logic k, input logic irq);
        exp_t ex;
        {pr_done, pr_req, step_i, pause_i, start_i} = in;
        ex.name = nm; ex.addr = a; ex.st = s; ex.en = e; ex.ack = k; ex.irq = irq;
        sb.push_back(ex);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        pause_i = 1'b0;
        step_i  = 1'b0;
    endtask

    task automatic test_reset();
        exp_t ex;
        for (int j = 0; j < 3; j++) begin
            rst_n = (j == 2);
            apply((j == 0) ? I_START : I_NONE, "reset", 4'd0, S_IDLE, 1'b0, 1'b0, 1'b0);
            ex = sb.pop_front();
            checks++;
            if ({shift_addr, state_o, shift_en, pr_ack} !== {ex.addr, ex.st, ex.en, ex.ack}) begin
                errors++;
                $display("FAIL %s[%0d]: addr=%0d st=%0d en=%0b ack=%0b, want addr=%0d st=%0d en=%0b ack=%0b",
                         ex.name, j, shift_addr, state_o, shift_en, pr_ack, ex.addr, ex.st, ex.en, ex.ack);
            end
`ifdef SHIFT_SCHED_WRAP_IRQ_EN
            checks++;
            if (wrap_irq !== ex.irq) begin
                errors++;
                $display("FAIL %s_irq[%0d]: wrap_irq=%0b want %0b", ex.name, j, wrap_irq, ex.irq);
            end
`endif
        end
    endtask

    // Start from IDLE and free-run through one full wrap, stopping at addr 5 with the prescaler at 0.
    task automatic test_run();
        exp_t       ex;
        logic [3:0] a;
        for (int k = 0; k <= 84; k++) begin
            a = 4'((k / 4) % 16);
            apply((k == 0) ? I_START : I_NONE, "run", a, S_RUN, 1'b1, 1'b0,
                  (k > 0) && (k % 4 == 0) && (a == 4'd0));
            ex = sb.pop_front();
            checks++;
            if ({shift_addr, state_o, shift_en, pr_ack} !== {ex.addr, ex.st, ex.en, ex.ack}) begin
                errors++;
                $display("FAIL %s[%0d]: addr=%0d st=%0d en=%0b ack=%0b, want addr=%0d st=%0d en=%0b ack=%0b",
                         ex.name, k, shift_addr, state_o, shift_en, pr_ack, ex.addr, ex.st, ex.en, ex.ack);
            end
`ifdef SHIFT_SCHED_WRAP_IRQ_EN
            checks++;
            if (wrap_irq !== ex.irq) begin
                errors++;
                $display("FAIL %s_irq[%0d]: wrap_irq=%0b want %0b", ex.name, k, wrap_irq, ex.irq);
            end
`endif
        end
    endtask

    task automatic test_pause_step();
        exp_t       ex;
        logic [4:0] in;
        logic [3:0] a;
        logic [2:0] s;
        for (int j = 0; j <= 29; j++) begin
            in = I_NONE;
            s  = S_PAUSE;
            a  = 4'd5;
            if (j == 0) in = I_PAUSE;
            if (j == 21 || j == 23 || j == 24) in = I_STEP;
            if (j == 25) in = I_START;
            if (j >= 21) a = 4'd6;
            if (j >= 23) a = 4'd7;
            if (j >= 24) a = 4'd8;
            if (j >= 25) s = S_RUN;
            if (j == 29) a = 4'd9;
            apply(in, "pause_step", a, s, 1'b1, 1'b0, 1'b0);
            ex = sb.pop_front();
            checks++;
            if ({shift_addr, state_o, shift_en, pr_ack} !== {ex.addr, ex.st, ex.en, ex.ack}) begin
                errors++;
                $display("FAIL %s[%0d]: addr=%0d st=%0d en=%0b ack=%0b, want addr=%0d st=%0d en=%0b ack=%0b",
                         ex.name, j, shift_addr, state_o, shift_en, pr_ack, ex.addr, ex.st, ex.en, ex.ack);
            end
        end
    endtask

    task automatic test_pr_handshake();
        exp_t       ex;
        logic [4:0] in_tab [11];
        logic [3:0] a_tab  [11];
        logic [2:0] s_tab  [11];
        in_tab = '{I_NONE, I_NONE, I_REQ, I_REQ, I_REQ | I_DONE, I_REQ, I_NONE,
                   I_START | I_STEP, I_DONE, I_NONE, I_NONE};
        a_tab  = '{4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd10};
        s_tab  = '{S_RUN, S_RUN, S_GUARD, S_GUARD, S_GUARD, S_DEC, S_DEC, S_DEC,
                   S_RUN, S_RUN, S_RUN};
        for (int j = 0; j < 11; j++) begin
            apply(in_tab[j], "pr_handshake", a_tab[j], s_tab[j],
                  s_tab[j] == S_RUN, s_tab[j] == S_DEC, 1'b0);
            ex = sb.pop_front();
            checks++;
            if ({shift_addr, state_o, shift_en, pr_ack} !== {ex.addr, ex.st, ex.en, ex.ack}) begin
                errors++;
                $display("FAIL %s[%0d]: addr=%0d st=%0d en=%0b ack=%0b, want addr=%0d st=%0d en=%0b ack=%0b",
                         ex.name, j, shift_addr, state_o, shift_en, pr_ack, ex.addr, ex.st, ex.en, ex.ack);
            end
        end
    endtask

    task automatic test_priority();
        exp_t       ex;
        logic [4:0] in_tab [8];
        logic [3:0] a_tab  [8];
        logic [2:0] s_tab  [8];
        in_tab = '{I_REQ | I_PAUSE | I_START, I_NONE, I_NONE, I_NONE, I_NONE, I_NONE,
                   I_PAUSE | I_START, I_START | I_STEP};
        a_tab  = '{4'd10, 4'd10, 4'd10, 4'd10, 4'd10, 4'd11, 4'd11, 4'd11};
        s_tab  = '{S_GUARD, S_RUN, S_RUN, S_RUN, S_RUN, S_RUN, S_PAUSE, S_RUN};
        for (int j = 0; j < 8; j++) begin
            apply(in_tab[j], "priority", a_tab[j], s_tab[j],
                  s_tab[j] != S_GUARD, 1'b0, 1'b0);
            ex = sb.pop_front();
            checks++;
            if ({shift_addr, state_o, shift_en, pr_ack} !== {ex.addr, ex.st, ex.en, ex.ack}) begin
                errors++;
                $display("FAIL %s[%0d]: addr=%0d st=%0d en=%0b ack=%0b, want addr=%0d st=%0d en=%0b ack=%0b",
                         ex.name, j, shift_addr, state_o, shift_en, pr_ack, ex.addr, ex.st, ex.en, ex.ack);
            end
        end
    endtask

    task automatic test_reset_mid_pr();
        exp_t       ex;
        logic [4:0] in_tab [7];
        logic [3:0] a_tab  [7];
        logic [2:0] s_tab  [7];
        in_tab = '{I_REQ, I_REQ, I_REQ, I_REQ, I_REQ, I_DONE, I_NONE};
        a_tab  = '{4'd11, 4'd11, 4'd11, 4'd11, 4'd0, 4'd0, 4'd0};
        s_tab  = '{S_GUARD, S_GUARD, S_GUARD, S_DEC, S_IDLE, S_IDLE, S_IDLE};
        for (int j = 0; j < 7; j++) begin
            rst_n = (j != 4);
            apply(in_tab[j], "reset_mid_pr", a_tab[j], s_tab[j], 1'b0, s_tab[j] == S_DEC, 1'b0);
            ex = sb.pop_front();
            checks++;
            if ({shift_addr, state_o, shift_en, pr_ack} !== {ex.addr, ex.st, ex.en, ex.ack}) begin
                errors++;
                $display("FAIL %s[%0d]: addr=%0d st=%0d en=%0b ack=%0b, want addr=%0d st=%0d en=%0b ack=%0b",
                         ex.name, j, shift_addr, state_o, shift_en, pr_ack, ex.addr, ex.st, ex.en, ex.ack);
            end
`ifdef SHIFT_SCHED_WRAP_IRQ_EN
            checks++;
            if (wrap_irq !== ex.irq) begin
                errors++;
                $display("FAIL %s_irq[%0d]: wrap_irq=%0b want %0b", ex.name, j, wrap_irq, ex.irq);
            end
`endif
        end
        rst_n = 1'b1;
    endtask

    task automatic test_ignored_step();
        exp_t       ex;
        logic [4:0] in_tab [8];
        logic [3:0] a_tab  [8];
        logic [2:0] s_tab  [8];
        in_tab = '{I_STEP, I_START, I_NONE, I_STEP, I_NONE, I_NONE, I_PAUSE, I_STEP};
        a_tab  = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd2};
        s_tab  = '{S_IDLE, S_RUN, S_RUN, S_RUN, S_RUN, S_RUN, S_PAUSE, S_PAUSE};
        for (int j = 0; j < 8; j++) begin
            apply(in_tab[j], "ignored_step", a_tab[j], s_tab[j], s_tab[j] != S_IDLE, 1'b0, 1'b0);
            ex = sb.pop_front();
            checks++;
            if ({shift_addr, state_o, shift_en, pr_ack} !== {ex.addr, ex.st, ex.en, ex.ack}) begin
                errors++;
                $display("FAIL %s[%0d]: addr=%0d st=%0d en=%0b ack=%0b, want addr=%0d st=%0d en=%0b ack=%0b",
                         ex.name, j, shift_addr, state_o, shift_en, pr_ack, ex.addr, ex.st, ex.en, ex.ack);
            end
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_pause_step();
        test_pr_handshake();
        test_priority();
        test_reset_mid_pr();
        test_ignored_step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
